frame_loader: RTL and testbench

Upstream feeder for the LED matrix panel driver. It receives a byte stream over a valid/ready handshake, frames it with a sync byte, and packs each group of 3 bytes into one 24-bit pixel-pair word. It then writes that word into the shared frame RAM at the addresses the panel driver scans (word = `row*96 + column`). The panel driver reads this RAM independently; this block only drives the RAM write port.

---
 rtl/frame_loader_if.sv | 46 ++++
 rtl/frame_loader.sv | 154 +++++++++++++++
 tb/tb_frame_loader.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_loader_if.sv
// rtl/frame_loader_if.sv - byte stream input, frame RAM write port and status outputs of frame_loader
//
// Signals:
//   i_rx_data / i_rx_valid / o_rx_ready : byte stream, transfer on valid && ready at a rising edge
//   o_ram_wr_addr / o_ram_wr_data       : registered RAM word address (0..2303) and 24-bit pixel pair
//   o_ram_wr_stb                        : one-cycle write strobe qualifying addr/data
//   o_frame_done / o_frame_error        : one-cycle frame completion / timeout abort pulses
//   o_busy                              : a frame is being loaded
// Modports:
//   master : the byte source / status consumer
//   slave  : frame_loader itself
interface frame_loader_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [11:0] o_ram_wr_addr;
    logic [23:0] o_ram_wr_data;
    logic        o_ram_wr_stb;
    logic        o_frame_done;
    logic        o_frame_error;
    logic        o_busy;

    modport master (
        output i_rx_data,
        output i_rx_valid,
        input  o_rx_ready,
        input  o_ram_wr_addr,
        input  o_ram_wr_data,
        input  o_ram_wr_stb,
        input  o_frame_done,
        input  o_frame_error,
        input  o_busy
    );

    modport slave (
        input  i_rx_data,
        input  i_rx_valid,
        output o_rx_ready,
        output o_ram_wr_addr,
        output o_ram_wr_data,
        output o_ram_wr_stb,
        output o_frame_done,
        output o_frame_error,
        output o_busy
    );
endinterface

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - sync-framed byte stream to LED panel frame RAM word writer
//
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-low reset
//   bus    : frame_loader_if.slave (byte stream in, RAM write port and status out)
// Each frame starts with SYNC_BYTE, followed by PIXELS_PER_ROW*ROWS groups of
// three bytes; each group becomes one 24-bit word written at consecutive
// addresses starting from 0.
module frame_loader #(
    parameter int unsigned PIXELS_PER_ROW = 96,
    parameter int unsigned ROWS           = 24,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    frame_loader_if.slave bus
);
    localparam int unsigned FRAME_WORDS = PIXELS_PER_ROW * ROWS;
    localparam logic [11:0] LAST_ADDR   = 12'(FRAME_WORDS - 1);
    localparam int unsigned TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [11:0]   ptr;
    logic [1:0]    idx;
    logic [TW-1:0] tcnt;
    logic [15:0]   asm_q;
    logic [11:0]   wr_addr_q;
    logic [23:0]   wr_data_q;
    logic          err_q;

    logic          rx_ready;
    logic          accept;
    logic          is_sync;
    logic          timeout_hit;

    // Status outputs are gated by reset so that nothing, including a write
    // strobe already in flight, is visible while i_rst is held low.
    assign rx_ready = i_rst && ((state == S_IDLE) || (state == S_LOAD));
    assign accept   = bus.i_rx_valid && rx_ready;
    assign is_sync  = (bus.i_rx_data == SYNC_BYTE);

    assign bus.o_rx_ready    = rx_ready;
    assign bus.o_ram_wr_stb  = i_rst && (state == S_WRITE);
    assign bus.o_frame_done  = i_rst && (state == S_DONE);
    assign bus.o_frame_error = i_rst && err_q;
    assign bus.o_busy        = i_rst && (state != S_IDLE);
    assign bus.o_ram_wr_addr = wr_addr_q;
    assign bus.o_ram_wr_data = wr_data_q;

    always_comb begin
        state_nx    = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_sync) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (idx == 2'd2) begin
                        state_nx = S_WRITE;
                    end
                end else if (tcnt == TLAST) begin
                    // An accept in the same cycle always wins over the abort.
                    state_nx    = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_WRITE: begin
                state_nx = (ptr == LAST_ADDR) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            idx       <= '0;
            tcnt      <= '0;
            asm_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= timeout_hit;
            case (state)
                S_IDLE: begin
                    if (accept && is_sync) begin
                        ptr  <= '0;
                        idx  <= '0;
                        tcnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        tcnt <= '0;
                        case (idx)
                            2'd0: begin
                                asm_q[15:8] <= bus.i_rx_data;
                                idx         <= 2'd1;
                            end
                            2'd1: begin
                                asm_q[7:0] <= bus.i_rx_data;
                                idx        <= 2'd2;
                            end
                            default: begin
                                // Address/data are latched here and then held
                                // untouched until the next completed word.
                                wr_addr_q <= ptr;
                                wr_data_q <= {asm_q, bus.i_rx_data};
                            end
                        endcase
                    end else if (timeout_hit) begin
                        ptr  <= '0;
                        idx  <= '0;
                        tcnt <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    // The pointer stops at the last word; only a new sync
                    // brings it back to 0.
                    if (ptr != LAST_ADDR) begin
                        ptr <= ptr + 12'd1;
                        idx <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - self-checking bench for frame_loader
module tb_frame_loader;
    localparam int WORDS = 2304;
    localparam int TMO   = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    frame_loader_if bus ();

    frame_loader #(
        .PIXELS_PER_ROW(96),
        .ROWS          (24),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_word(input int n);
        logic [7:0] a, b, c;
        a = 8'(3 * n);
        b = 8'(3 * n + 1);
        c = 8'(3 * n + 2);
        return {a, b, c};
    endfunction

    // Observations of the DUT (written only by the compare process).
    int          n_stb = 0, n_done = 0, n_err = 0;
    int          done_cyc = -1, err_cyc = -1, sync_cyc = -1, last_acc_cyc = -1;
    logic [11:0] cap_addr  = '0;
    logic [23:0] cap_data  = '0;
    logic        cap_ready = 1'b0;
    logic [23:0] dut_ram [WORDS] = '{default: '0};
    int          wr_at   [WORDS] = '{default: -1};

    // Behavioural model: what the outputs must be, in terms of cycle numbers.
    bit          m_in_frame = 1'b0;
    int          m_nb = 0, m_ptr = 0;
    int          m_wr_cyc = -1, m_done_cyc = -1, m_err_cyc = -1, m_dead = -1;
    logic [7:0]  m_b0 = '0, m_b1 = '0;
    logic [11:0] m_addr = '0;
    logic [23:0] m_data = '0;
    bit          rst_seen = 1'b0;

    always @(negedge i_clk) begin : compare
        int   n;
        bit   acc;
        logic e_stb, e_done, e_err, e_rdy, e_busy;
        n = cyc;
        if (!i_rst) begin
            chk("reset_outputs",
                {bus.o_ram_wr_stb, bus.o_rx_ready, bus.o_busy, bus.o_frame_done, bus.o_frame_error}, 0);
            if (rst_seen)
                chk("reset_addr_data", {bus.o_ram_wr_addr, bus.o_ram_wr_data}, 0);
            rst_seen   = 1'b1;
            m_in_frame = 1'b0;
            m_nb       = 0;
            m_ptr      = 0;
            m_wr_cyc   = -1;
            m_done_cyc = -1;
            m_err_cyc  = -1;
            m_dead     = -1;
            m_addr     = '0;
            m_data     = '0;
        end else begin
            rst_seen = 1'b0;
            e_stb    = (n == m_wr_cyc);
            e_done   = (n == m_done_cyc);
            e_err    = (n == m_err_cyc);
            e_rdy    = !(e_stb || e_done);
            e_busy   = m_in_frame || e_stb || e_done;
            chk("cycle_outputs",
                {bus.o_ram_wr_stb, bus.o_rx_ready, bus.o_busy, bus.o_frame_done, bus.o_frame_error,
                 bus.o_ram_wr_addr, bus.o_ram_wr_data},
                {e_stb, e_rdy, e_busy, e_done, e_err, m_addr, m_data});

            if (bus.o_ram_wr_stb) begin
                n_stb++;
                cap_addr  = bus.o_ram_wr_addr;
                cap_data  = bus.o_ram_wr_data;
                cap_ready = bus.o_rx_ready;
                if (bus.o_ram_wr_addr < 12'(WORDS)) begin
                    dut_ram[bus.o_ram_wr_addr] = bus.o_ram_wr_data;
                    wr_at[bus.o_ram_wr_addr]   = n;
                end
            end
            if (bus.o_frame_done) begin
                n_done++;
                done_cyc = n;
            end
            if (bus.o_frame_error) begin
                n_err++;
                err_cyc = n;
            end

            // Advance the model with this cycle's transfer (happens at the next edge).
            acc = bus.i_rx_valid && e_rdy;
            if (acc) begin
                last_acc_cyc = n;
                if (!m_in_frame) begin
                    if (bus.i_rx_data == 8'hA5) begin
                        m_in_frame = 1'b1;
                        m_nb       = 0;
                        m_ptr      = 0;
                        m_dead     = n + TMO + 1;
                        sync_cyc   = n;
                    end
                end else if (m_nb == 0) begin
                    m_b0   = bus.i_rx_data;
                    m_nb   = 1;
                    m_dead = n + TMO + 1;
                end else if (m_nb == 1) begin
                    m_b1   = bus.i_rx_data;
                    m_nb   = 2;
                    m_dead = n + TMO + 1;
                end else begin
                    m_nb     = 0;
                    m_wr_cyc = n + 1;
                    m_addr   = 12'(m_ptr);
                    m_data   = {m_b0, m_b1, bus.i_rx_data};
                    // The write cycle does not count toward the idle gap.
                    m_dead   = n + TMO + 2;
                    if (m_ptr == WORDS - 1) begin
                        m_done_cyc = n + 2;
                        m_in_frame = 1'b0;
                    end else begin
                        m_ptr++;
                    end
                end
            end else if (m_in_frame && (n + 1 == m_dead)) begin
                m_err_cyc  = n + 1;
                m_in_frame = 1'b0;
                m_nb       = 0;
                m_ptr      = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        bit rdy;
        bus.i_rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge i_clk);
            #1;
        end
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge i_clk);
            rdy = bus.o_rx_ready;
            @(posedge i_clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 20) begin
                checks++;
                errors++;
                $display("FAIL send_accept: byte %h still pending after %0d cycles, required accept", b, t);
                break;
            end
        end
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (n_done == d0 && t < 40) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        if (n_done == d0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no frame_done within %0d cycles, required one", t);
        end
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int         s0, d0, e0, t0, bad, la;
        logic [7:0] seq[$];

        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        i_rst          = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("reset_release_ready", bus.o_rx_ready, 1);
        chk("reset_release_busy", bus.o_busy, 0);
        chk("reset_release_addr", bus.o_ram_wr_addr, 0);
        @(posedge i_clk);
        #1;

        // Packing.
        s0 = n_stb;
        e0 = n_err;
        send(8'hA5, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 0);
        idle(3);
        chk("pack_strobes", n_stb - s0, 1);
        chk("pack_addr", cap_addr, 0);
        chk("pack_data", cap_data, 24'h123456);
        chk("pack_ready_in_strobe", cap_ready, 0);
        idle(TMO + 4);
        chk("pack_trailing_timeout", n_err - e0, 1);

        // Garbage before sync, sync byte used as pixel data.
        s0  = n_stb;
        seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h44};
        foreach (seq[i]) send(seq[i], 0);
        idle(3);
        chk("garbage_strobes", n_stb - s0, 2);
        chk("garbage_addr", cap_addr, 1);
        chk("garbage_data", cap_data, 24'h33A544);
        chk("garbage_word0", dut_ram[0], 24'hA51122);
        idle(TMO + 4);

        // Timeout abort and restart.
        s0 = n_stb;
        e0 = n_err;
        seq = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
        foreach (seq[i]) send(seq[i], 0);
        la = last_acc_cyc;
        idle(TMO + 6);
        chk("timeout_strobes", n_stb - s0, 1);
        chk("timeout_addr", cap_addr, 0);
        chk("timeout_data", cap_data, 24'h010203);
        chk("timeout_pulses", n_err - e0, 1);
        chk("timeout_latency", err_cyc - (la + 1), 16);
        chk("timeout_idle_busy", bus.o_busy, 0);
        seq = '{8'hA5, 8'h07, 8'h08, 8'h09};
        foreach (seq[i]) send(seq[i], 0);
        idle(3);
        chk("restart_addr", cap_addr, 0);
        chk("restart_data", cap_data, 24'h070809);
        idle(TMO + 4);

        // Full frame at full rate.
        s0 = n_stb;
        d0 = n_done;
        e0 = n_err;
        t0 = cyc;
        send(8'hA5, 0);
        for (int k = 0; k < 3 * WORDS; k++) send(8'(k), 0);
        wait_done(d0);
        idle(4);
        chk("full_strobes", n_stb - s0, WORDS);
        chk("full_done_pulses", n_done - d0, 1);
        chk("full_done_latency", done_cyc - sync_cyc, 9217);
        chk("full_no_error", n_err - e0, 0);
        bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (wr_at[i] < t0 || dut_ram[i] !== exp_word(i)) bad++;
        chk("full_ram_words_wrong", bad, 0);
        chk("full_word85", dut_ram[85], 24'hFF0001);
        chk("full_word2303", dut_ram[2303], 24'hFDFEFF);

        // Same frame with valid gaps, including the longest gap that must not time out.
        d0 = n_done;
        e0 = n_err;
        t0 = cyc;
        send(8'hA5, 0);
        for (int k = 0; k < 3 * WORDS; k++) begin
            int g;
            g = (k % 211 == 5) ? TMO - 1 : int'($urandom_range(0, 3));
            send(8'(k), g);
        end
        wait_done(d0);
        idle(4);
        chk("gap_done_pulses", n_done - d0, 1);
        chk("gap_no_error", n_err - e0, 0);
        bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (wr_at[i] < t0 || dut_ram[i] !== exp_word(i)) bad++;
        chk("gap_ram_words_wrong", bad, 0);

        // Reset in the write cycle of word 100.
        send(8'hA5, 0);
        for (int k = 0; k < 303; k++) send(8'(k), 0);
        s0 = n_stb;
        i_rst = 1'b0;
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'hA5;
        idle(3);
        chk("reset_no_strobe", n_stb - s0, 0);
        i_rst = 1'b1;
        bus.i_rx_valid = 1'b0;
        seq = '{8'h11, 8'h22, 8'h33};
        foreach (seq[i]) send(seq[i], 0);
        idle(3);
        chk("post_reset_ignored", n_stb - s0, 0);
        seq = '{8'hA5, 8'hAB, 8'hCD, 8'hEF};
        foreach (seq[i]) send(seq[i], 0);
        idle(3);
        chk("post_reset_strobes", n_stb - s0, 1);
        chk("post_reset_addr", cap_addr, 0);
        chk("post_reset_data", cap_data, 24'hABCDEF);
        idle(TMO + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
